// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and constants for the two-master data-memory
// arbiter.
//   state_t  - arbiter FSM states (IDLE grants, RD_DATA returns read data)
//   M0 / M1  - master index constants
//   CNT_MAX  - saturation value of the wait counters
package dmem_arb_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_DATA = 1'b1
  } state_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  localparam logic [31:0] CNT_MAX = '1;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin selector.
// Ports:
//   req[1:0]  - request from master 0 / master 1
//   last      - index of the master granted most recently
//   gnt       - index of the winning master (valid when gnt_valid)
//   gnt_valid - at least one request present
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt,
  output logic       gnt_valid
);

  always_comb begin
    gnt_valid = |req;
    // Tie goes to the master that was not granted last; otherwise the
    // lone requester (req[1] alone selects 1, req[0] alone selects 0).
    if (req == 2'b11) gnt = ~last;
    else              gnt = req[1];
  end

endmodule

// File: rtl/dmem_arb.sv
// dmem_arb: round-robin arbiter giving two masters access to one
// single-port synchronous SRAM. Writes complete in the grant cycle; reads
// return data one cycle after the grant (RD_DATA state).
// Ports:
//   clk, rst                         - clock, async active-high reset
//   mN_addr/rd_req/wr_req/wr_be/wr_data - master N request side
//   mN_rd_ready/wr_ready/rd_data     - master N completion side
//   mem_cs/we/be/addr/wdata, mem_rdata - SRAM port
//   perf_clr, mN_wait_cnt            - contention counters
// Build option: define DMEM_ARB_PERF_EN to implement the wait counters;
// otherwise they read as zero and perf_clr is ignored.
module dmem_arb
  import dmem_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   m0_addr,
  input  logic            m0_rd_req,
  input  logic            m0_wr_req,
  input  logic [DW/8-1:0] m0_wr_be,
  input  logic [DW-1:0]   m0_wr_data,
  output logic            m0_rd_ready,
  output logic            m0_wr_ready,
  output logic [DW-1:0]   m0_rd_data,
  input  logic [AW-1:0]   m1_addr,
  input  logic            m1_rd_req,
  input  logic            m1_wr_req,
  input  logic [DW/8-1:0] m1_wr_be,
  input  logic [DW-1:0]   m1_wr_data,
  output logic            m1_rd_ready,
  output logic            m1_wr_ready,
  output logic [DW-1:0]   m1_rd_data,
  output logic            mem_cs,
  output logic            mem_we,
  output logic [DW/8-1:0] mem_be,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata,
  input  logic            perf_clr,
  output logic [31:0]     m0_wait_cnt,
  output logic [31:0]     m1_wait_cnt
);

  state_t     state_q, state_d;
  logic       owner_q, owner_d;
  logic       last_q,  last_d;
  logic [1:0] req;
  logic       win, win_vld, win_rd;
  logic [1:0] rd_rdy, wr_rdy;

  assign req = {m1_rd_req | m1_wr_req, m0_rd_req | m0_wr_req};

  rr_arb2 u_rr (
    .req       (req),
    .last      (last_q),
    .gnt       (win),
    .gnt_valid (win_vld)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    mem_cs    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = win ? m1_addr    : m0_addr;
    mem_be    = win ? m1_wr_be   : m0_wr_be;
    mem_wdata = win ? m1_wr_data : m0_wr_data;
    win_rd    = win ? m1_rd_req  : m0_rd_req;
    rd_rdy    = '0;
    wr_rdy    = '0;
    // Outputs are forced quiet while reset is held, even with requests up.
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (win_vld) begin
            mem_cs = 1'b1;
            last_d = win;
            // A read takes priority over a simultaneous write from the
            // same master; the write stays pending.
            if (win_rd) begin
              owner_d = win;
              state_d = RD_DATA;
            end else begin
              mem_we      = 1'b1;
              wr_rdy[win] = 1'b1;
            end
          end
        end
        RD_DATA: begin
          rd_rdy[owner_q] = 1'b1;
          state_d         = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= M0;
      last_q  <= M1;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  assign m0_rd_ready = rd_rdy[M0];
  assign m1_rd_ready = rd_rdy[M1];
  assign m0_wr_ready = wr_rdy[M0];
  assign m1_wr_ready = wr_rdy[M1];
  assign m0_rd_data  = mem_rdata;
  assign m1_rd_data  = mem_rdata;

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] wait0_q, wait1_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait0_q <= '0;
      wait1_q <= '0;
    end else if (perf_clr) begin
      wait0_q <= '0;
      wait1_q <= '0;
    end else begin
      if (req[M0] && !(rd_rdy[M0] || wr_rdy[M0]) && wait0_q != CNT_MAX)
        wait0_q <= wait0_q + 32'd1;
      if (req[M1] && !(rd_rdy[M1] || wr_rdy[M1]) && wait1_q != CNT_MAX)
        wait1_q <= wait1_q + 32'd1;
    end
  end

  assign m0_wait_cnt = wait0_q;
  assign m1_wait_cnt = wait1_q;
`else
  logic unused_perf_clr;
  assign unused_perf_clr = perf_clr;
  assign m0_wait_cnt     = '0;
  assign m1_wait_cnt     = '0;
`endif

endmodule

// File: tb/tb_dmem_arb.sv
module tb_dmem_arb;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] m0_addr, m1_addr;
  logic          m0_rd_req, m0_wr_req, m1_rd_req, m1_wr_req;
  logic [BW-1:0] m0_wr_be, m1_wr_be;
  logic [DW-1:0] m0_wr_data, m1_wr_data;
  logic          m0_rd_ready, m0_wr_ready, m1_rd_ready, m1_wr_ready;
  logic [DW-1:0] m0_rd_data, m1_rd_data;
  logic          mem_cs, mem_we;
  logic [BW-1:0] mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          perf_clr;
  logic [31:0]   m0_wait_cnt, m1_wait_cnt;

  always #5 clk = ~clk;

  dmem_arb #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .m0_addr(m0_addr), .m0_rd_req(m0_rd_req), .m0_wr_req(m0_wr_req),
    .m0_wr_be(m0_wr_be), .m0_wr_data(m0_wr_data),
    .m0_rd_ready(m0_rd_ready), .m0_wr_ready(m0_wr_ready), .m0_rd_data(m0_rd_data),
    .m1_addr(m1_addr), .m1_rd_req(m1_rd_req), .m1_wr_req(m1_wr_req),
    .m1_wr_be(m1_wr_be), .m1_wr_data(m1_wr_data),
    .m1_rd_ready(m1_rd_ready), .m1_wr_ready(m1_wr_ready), .m1_rd_data(m1_rd_data),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .perf_clr(perf_clr), .m0_wait_cnt(m0_wait_cnt), .m1_wait_cnt(m1_wait_cnt)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: is a read awaiting its data cycle, whose, who won last.
  bit          rd_pending;
  int          rd_who;
  int          prev_winner;
  int unsigned waits[2];
  bit          e_rr[2], e_wr[2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge with inputs set: checks this cycle's
  // outputs against the model, advances the model across the rising edge.
  task automatic cyc();
    bit            rq[2], rdq[2];
    logic [AW-1:0] ad[2];
    logic [BW-1:0] be[2];
    logic [DW-1:0] wd[2];
    bit            exp_cs, exp_we;
    int            w;
    #1;
    rq[0]  = m0_rd_req | m0_wr_req;  rq[1]  = m1_rd_req | m1_wr_req;
    rdq[0] = m0_rd_req;              rdq[1] = m1_rd_req;
    ad[0]  = m0_addr;    ad[1] = m1_addr;
    be[0]  = m0_wr_be;   be[1] = m1_wr_be;
    wd[0]  = m0_wr_data; wd[1] = m1_wr_data;
    e_rr = '{0, 0}; e_wr = '{0, 0};
    exp_cs = 0; exp_we = 0;
    if (rst) begin
      rd_pending  = 0;
      prev_winner = 1;
      waits       = '{0, 0};
    end else if (rd_pending) begin
      e_rr[rd_who] = 1;
      rd_pending   = 0;
    end else if (rq[0] || rq[1]) begin
      if (rq[0] && rq[1]) w = 1 - prev_winner;
      else                w = rq[1] ? 1 : 0;
      exp_cs = 1;
      chk("mem_addr", mem_addr, ad[w]);
      if (rdq[w]) begin
        rd_pending = 1;
        rd_who     = w;
      end else begin
        exp_we  = 1;
        e_wr[w] = 1;
        chk("mem_be", mem_be, be[w]);
        chk("mem_wdata", mem_wdata, wd[w]);
      end
      prev_winner = w;
    end
    chk("mem_cs", mem_cs, exp_cs);
    chk("mem_we", mem_we, exp_we);
    chk("m0_rd_ready", m0_rd_ready, e_rr[0]);
    chk("m1_rd_ready", m1_rd_ready, e_rr[1]);
    chk("m0_wr_ready", m0_wr_ready, e_wr[0]);
    chk("m1_wr_ready", m1_wr_ready, e_wr[1]);
    if (e_rr[0]) chk("m0_rd_data", m0_rd_data, mem_rdata);
    if (e_rr[1]) chk("m1_rd_data", m1_rd_data, mem_rdata);
`ifdef DMEM_ARB_PERF_EN
    chk("m0_wait_cnt", m0_wait_cnt, waits[0]);
    chk("m1_wait_cnt", m1_wait_cnt, waits[1]);
    if (!rst) begin
      if (perf_clr) waits = '{0, 0};
      else
        for (int i = 0; i < 2; i++)
          if (rq[i] && !e_rr[i] && !e_wr[i] && waits[i] != 32'hFFFF_FFFF) waits[i]++;
    end
`else
    chk("m0_wait_cnt", m0_wait_cnt, 0);
    chk("m1_wait_cnt", m1_wait_cnt, 0);
`endif
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    int k;
    rst = 1'b1; perf_clr = 1'b0; mem_rdata = '0;
    m0_addr = '0; m0_rd_req = 0; m0_wr_req = 0; m0_wr_be = '0; m0_wr_data = '0;
    m1_addr = '0; m1_rd_req = 0; m1_wr_req = 0; m1_wr_be = '0; m1_wr_data = '0;
    rd_pending = 0; rd_who = 0; prev_winner = 1; waits = '{0, 0};
    @(negedge clk);
    do_reset();

    // Single M0 write: zero wait states, be=3.
    m0_addr = 32'h100; m0_wr_be = 4'h3; m0_wr_data = 32'h1234_ABCD; m0_wr_req = 1;
    #1;
    chk("w0_cs", mem_cs, 1'b1);
    chk("w0_be", mem_be, 4'h3);
    chk("w0_ready", m0_wr_ready, 1'b1);
    cyc();
    m0_wr_req = 0;

    // Single M1 read with data returned one cycle later.
    m1_addr = 32'h40; m1_rd_req = 1; mem_rdata = 32'hDEAD_BEEF;
    cyc();
    cyc();
    m1_rd_req = 0;

    // Two masters holding writes from reset alternate M0, M1, M0, M1.
    do_reset();
    m1_wr_be = 4'hF; m1_wr_data = 32'h5555_AAAA; m1_addr = 32'h200;
    m0_wr_req = 1; m1_wr_req = 1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("rr_order_m0", e_wr[0], (i % 2) == 0);
    end
    m0_wr_req = 0; m1_wr_req = 0;

    // Write arriving during RD_DATA waits for the next IDLE cycle.
    m0_rd_req = 1; m0_addr = 32'h300;
    cyc();
    m1_wr_req = 1; mem_rdata = 32'h0BAD_F00D;
    cyc();
    m0_rd_req = 0;
    cyc();
    m1_wr_req = 0;

    // Reset while in RD_DATA aborts the read.
    m0_rd_req = 1;
    cyc();
    m0_rd_req = 0;
    do_reset();
    cyc();
    cyc();

    // Contention: M1 read waits behind an M0 read (3 waiting cycles).
    m0_rd_req = 1; m1_rd_req = 1;
    cyc();
    cyc();
    m0_rd_req = 0;
    cyc();
    cyc();
    m1_rd_req = 0;
    cyc();
    perf_clr = 1;
    cyc();
    perf_clr = 0;
    cyc();

    // Randomised traffic with occasional reset and counter clear.
    for (int n = 0; n < 600; n++) begin
      mem_rdata = $urandom;
      perf_clr  = ($urandom_range(0, 40) == 0);
      rst       = ($urandom_range(0, 80) == 0);
      cyc();
      rst = 0;
      if (e_rr[0]) m0_rd_req = 0;
      if (e_wr[0]) m0_wr_req = 0;
      if (e_rr[1]) m1_rd_req = 0;
      if (e_wr[1]) m1_wr_req = 0;
      if (!m0_rd_req && !m0_wr_req && $urandom_range(0, 2) != 0) begin
        k = $urandom_range(0, 4);
        m0_rd_req = (k < 2) || (k == 4); m0_wr_req = (k >= 2);
        m0_addr = $urandom; m0_wr_be = $urandom; m0_wr_data = $urandom;
      end
      if (!m1_rd_req && !m1_wr_req && $urandom_range(0, 2) != 0) begin
        k = $urandom_range(0, 4);
        m1_rd_req = (k < 2) || (k == 4); m1_wr_req = (k >= 2);
        m1_addr = $urandom; m1_wr_be = $urandom; m1_wr_data = $urandom;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
